// File: rtl/wb_commit_buffer_if.sv
// Bundle between the speculative write-back buffer, the pipeline and the register file.
// Latency: wires only; no state lives in the interface.
// Backpressure: ready_o tells the pipeline when a write will be accepted.
// Ports: pipeline write (we/waddr/wdata/ready), commit/replay pulses, two read ports
// with register file read data and forwarded data, register file write port, status.
interface wb_commit_buffer_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 8
);
   localparam int CW = $clog2(DEPTH) + 1;

   logic                  we_i;
   logic [ADDR_WIDTH-1:0] waddr_i;
   logic [DATA_WIDTH-1:0] wdata_i;
   logic                  ready_o;
   logic                  commit_i;
   logic                  replay_i;
   logic [ADDR_WIDTH-1:0] raddr_a_i;
   logic [ADDR_WIDTH-1:0] raddr_b_i;
   logic [DATA_WIDTH-1:0] rf_rdata_a_i;
   logic [DATA_WIDTH-1:0] rf_rdata_b_i;
   logic [DATA_WIDTH-1:0] rdata_a_o;
   logic [DATA_WIDTH-1:0] rdata_b_o;
   logic                  rf_we_o;
   logic [ADDR_WIDTH-1:0] rf_waddr_o;
   logic [DATA_WIDTH-1:0] rf_wdata_o;
   logic                  empty_o;
   logic [CW-1:0]         spec_cnt_o;

   // Buffer side
   modport slave (
      input  we_i, waddr_i, wdata_i, commit_i, replay_i,
      input  raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
      output ready_o, rdata_a_o, rdata_b_o,
      output rf_we_o, rf_waddr_o, rf_wdata_o, empty_o, spec_cnt_o
   );

   // Pipeline / register file side
   modport master (
      output we_i, waddr_i, wdata_i, commit_i, replay_i,
      output raddr_a_i, raddr_b_i, rf_rdata_a_i, rf_rdata_b_i,
      input  ready_o, rdata_a_o, rdata_b_o,
      input  rf_we_o, rf_waddr_o, rf_wdata_o, empty_o, spec_cnt_o
   );
endinterface

// File: rtl/wb_commit_buffer.sv
// Speculative register write-back buffer: holds writes until commit, drains them in order to the RF.
// Latency: enqueue visible to reads next cycle; commit in cycle t drains from t+1, one entry per cycle.
// Backpressure: ready_o low when DEPTH entries are held; writes offered while full are dropped.
// Ports: clk, rst_n (async, active-low), bus (slave modport of wb_commit_buffer_if).
module wb_commit_buffer #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int DEPTH      = 8
) (
   input  logic            clk,
   input  logic            rst_n,
   wb_commit_buffer_if.slave bus
);
   localparam int IW = $clog2(DEPTH);
   localparam int PW = IW + 1;

   // Pointers carry an extra wrap bit so full and empty are distinguishable.
   logic [PW-1:0] head;   // oldest entry
   logic [PW-1:0] cmt;    // first speculative entry
   logic [PW-1:0] tail;   // next free slot
   logic [PW-1:0] used;

   logic [ADDR_WIDTH-1:0] mem_addr [DEPTH];
   logic [DATA_WIDTH-1:0] mem_data [DEPTH];

   logic enq;
   logic drain;
   logic ready;

   assign used  = tail - head;
   assign ready = (used != PW'(DEPTH));
   assign drain = (cmt != head);
   // A replay in the same cycle wipes the speculative region, so the new write goes with it.
   assign enq   = bus.we_i && ready && (bus.waddr_i != '0) && !bus.replay_i;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head <= '0;
         cmt  <= '0;
         tail <= '0;
      end else begin
         if (drain)
            head <= head + PW'(1);
         // Replay takes priority over a simultaneous commit.
         if (bus.replay_i) begin
            tail <= cmt;
         end else begin
            if (bus.commit_i)
               cmt <= tail;
            if (enq)
               tail <= tail + PW'(1);
         end
      end
   end

   // Storage has no reset: only slots inside [head, tail) are ever read.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_addr[tail[IW-1:0]] <= bus.waddr_i;
         mem_data[tail[IW-1:0]] <= bus.wdata_i;
      end
   end

   assign bus.ready_o    = ready;
   assign bus.empty_o    = (tail == head);
   assign bus.spec_cnt_o = tail - cmt;
   assign bus.rf_we_o    = drain;
   // Gated so the RF port reads zero when idle, including straight out of reset.
   assign bus.rf_waddr_o = drain ? mem_addr[head[IW-1:0]] : '0;
   assign bus.rf_wdata_o = drain ? mem_data[head[IW-1:0]] : '0;

   // Forwarding: walk from oldest to newest so the last match wins (youngest value).
   // The entry being drained this cycle is still in range and still forwards.
   always_comb begin
      logic [IW-1:0] idx;
      idx           = '0;
      bus.rdata_a_o = bus.rf_rdata_a_i;
      bus.rdata_b_o = bus.rf_rdata_b_i;
      for (int i = 0; i < DEPTH; i++) begin
         idx = head[IW-1:0] + IW'(i);
         if (PW'(i) < used) begin
            if (mem_addr[idx] == bus.raddr_a_i)
               bus.rdata_a_o = mem_data[idx];
            if (mem_addr[idx] == bus.raddr_b_i)
               bus.rdata_b_o = mem_data[idx];
         end
      end
      if (bus.raddr_a_i == '0)
         bus.rdata_a_o = '0;
      if (bus.raddr_b_i == '0)
         bus.rdata_b_o = '0;
   end
endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed bench for wb_commit_buffer: expected RF writes are queued when a commit is issued
// and a negedge monitor pops and compares them whenever rf_we_o is high.
// Status and forwarding outputs are compared directly against hand-computed constants.
module tb_wb_commit_buffer;
   localparam int DW = 32;
   localparam int AW = 5;
   localparam int DP = 8;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
   } wr_t;

   wr_t exp_q[$];

   wb_commit_buffer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) bus ();

   wb_commit_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DP)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Fake register file: read data identifies the address it came from.
   assign bus.rf_rdata_a_i = 32'hF000_0000 | 32'(bus.raddr_a_i);
   assign bus.rf_rdata_b_i = 32'hE000_0000 | 32'(bus.raddr_b_i);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every RF write must match the next queued expectation.
   always @(negedge clk) begin
      if (rst_n && bus.rf_we_o) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL rf_unexpected got addr %0d data %h expected no write",
                     bus.rf_waddr_o, bus.rf_wdata_o);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if (bus.rf_waddr_o !== e.addr || bus.rf_wdata_o !== e.data) begin
               errors++;
               $display("FAIL rf_write got addr %0d data %h expected addr %0d data %h",
                        bus.rf_waddr_o, bus.rf_wdata_o, e.addr, e.data);
            end
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      bus.we_i    = 1'b1;
      bus.waddr_i = a;
      bus.wdata_i = d;
      cyc();
      bus.we_i    = 1'b0;
   endtask

   task automatic expect_wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
      wr_t e;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      rst_n = 1'b0;
      bus.we_i = 1'b0;
      bus.waddr_i = '0;
      bus.wdata_i = '0;
      bus.commit_i = 1'b0;
      bus.replay_i = 1'b0;
      bus.raddr_a_i = 5'd5;
      bus.raddr_b_i = 5'd0;
      #12;
      // Reset state
      chk("rst_ready", 32'(bus.ready_o), 32'd1);
      chk("rst_empty", 32'(bus.empty_o), 32'd1);
      chk("rst_spec", 32'(bus.spec_cnt_o), 32'd0);
      chk("rst_rf_we", 32'(bus.rf_we_o), 32'd0);
      chk("rst_rf_waddr", 32'(bus.rf_waddr_o), 32'd0);
      chk("rst_rf_wdata", bus.rf_wdata_o, 32'd0);
      chk("rst_rdata_a", bus.rdata_a_o, 32'hF000_0005);
      chk("rst_rdata_b_x0", bus.rdata_b_o, 32'd0);
      rst_n = 1'b1;
      cyc();

      // Single write forwarded next cycle, held until commit
      wr(5'd5, 32'hA5A5_0001);
      chk("t1_fwd", bus.rdata_a_o, 32'hA5A5_0001);
      chk("t1_no_drain", 32'(bus.rf_we_o), 32'd0);
      chk("t1_spec", 32'(bus.spec_cnt_o), 32'd1);
      cyc();
      chk("t1_still_held", 32'(bus.rf_we_o), 32'd0);
      expect_wr(5'd5, 32'hA5A5_0001);
      bus.commit_i = 1'b1;
      cyc();
      bus.commit_i = 1'b0;
      chk("t1_drain", 32'(bus.rf_we_o), 32'd1);
      chk("t1_spec_after_commit", 32'(bus.spec_cnt_o), 32'd0);
      cyc();
      chk("t1_empty", 32'(bus.empty_o), 32'd1);

      // Youngest-match forwarding during an in-order drain
      wr(5'd1, 32'd1);
      wr(5'd2, 32'd2);
      wr(5'd1, 32'd3);
      bus.raddr_a_i = 5'd1;
      bus.raddr_b_i = 5'd2;
      #1;
      chk("t2_fwd_young", bus.rdata_a_o, 32'd3);
      chk("t2_fwd_b", bus.rdata_b_o, 32'd2);
      expect_wr(5'd1, 32'd1);
      expect_wr(5'd2, 32'd2);
      expect_wr(5'd1, 32'd3);
      bus.commit_i = 1'b1;
      cyc();
      bus.commit_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         chk("t2_drain_we", 32'(bus.rf_we_o), 32'd1);
         chk("t2_fwd_during_drain", bus.rdata_a_o, 32'd3);
         cyc();
      end
      chk("t2_drain_done", 32'(bus.rf_we_o), 32'd0);
      chk("t2_empty", 32'(bus.empty_o), 32'd1);

      // Replay discards speculative writes
      wr(5'd3, 32'h33);
      wr(5'd4, 32'h44);
      chk("t3_spec2", 32'(bus.spec_cnt_o), 32'd2);
      bus.replay_i = 1'b1;
      cyc();
      bus.replay_i = 1'b0;
      bus.raddr_a_i = 5'd3;
      #1;
      chk("t3_spec0", 32'(bus.spec_cnt_o), 32'd0);
      chk("t3_no_drain", 32'(bus.rf_we_o), 32'd0);
      chk("t3_empty", 32'(bus.empty_o), 32'd1);
      chk("t3_rf_passthru", bus.rdata_a_o, 32'hF000_0003);

      // Fill to DEPTH (pointers wrap), extra write dropped, full drain
      for (int i = 0; i < DP; i++)
         wr(5'(i + 1), 32'h100 + 32'(i));
      chk("t4_full_ready", 32'(bus.ready_o), 32'd0);
      chk("t4_full_spec", 32'(bus.spec_cnt_o), 32'd8);
      wr(5'd9, 32'h999);
      bus.raddr_b_i = 5'd9;
      #1;
      chk("t4_ninth_dropped", 32'(bus.spec_cnt_o), 32'd8);
      chk("t4_ninth_not_fwd", bus.rdata_b_o, 32'hE000_0009);
      for (int i = 0; i < DP; i++)
         expect_wr(5'(i + 1), 32'h100 + 32'(i));
      bus.commit_i = 1'b1;
      cyc();
      bus.commit_i = 1'b0;
      chk("t4_drain_start", 32'(bus.rf_we_o), 32'd1);
      chk("t4_ready_still_low", 32'(bus.ready_o), 32'd0);
      cyc();
      chk("t4_ready_after_drain", 32'(bus.ready_o), 32'd1);
      for (int i = 0; i < DP - 1; i++) begin
         chk("t4_not_empty", 32'(bus.empty_o), 32'd0);
         cyc();
      end
      chk("t4_empty", 32'(bus.empty_o), 32'd1);
      chk("t4_drain_end", 32'(bus.rf_we_o), 32'd0);

      // Commit and replay together: replay wins; x0 writes never enqueue
      wr(5'd10, 32'hA);
      wr(5'd11, 32'hB);
      bus.commit_i = 1'b1;
      bus.replay_i = 1'b1;
      cyc();
      bus.commit_i = 1'b0;
      bus.replay_i = 1'b0;
      chk("t5_spec0", 32'(bus.spec_cnt_o), 32'd0);
      chk("t5_empty", 32'(bus.empty_o), 32'd1);
      chk("t5_no_drain", 32'(bus.rf_we_o), 32'd0);
      wr(5'd0, 32'h123);
      chk("t5_x0_empty", 32'(bus.empty_o), 32'd1);
      chk("t5_x0_spec", 32'(bus.spec_cnt_o), 32'd0);
      cyc();
      chk("t5_x0_no_drain", 32'(bus.rf_we_o), 32'd0);

      // Reset in the middle of draining four committed entries
      wr(5'd12, 32'hC);
      wr(5'd13, 32'hD);
      wr(5'd14, 32'hE);
      wr(5'd15, 32'hF);
      expect_wr(5'd12, 32'hC);
      bus.commit_i = 1'b1;
      cyc();
      bus.commit_i = 1'b0;
      chk("t6_drain_start", 32'(bus.rf_we_o), 32'd1);
      @(negedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      chk("t6_rst_rf_we", 32'(bus.rf_we_o), 32'd0);
      chk("t6_rst_empty", 32'(bus.empty_o), 32'd1);
      chk("t6_rst_ready", 32'(bus.ready_o), 32'd1);
      chk("t6_rst_spec", 32'(bus.spec_cnt_o), 32'd0);
      cyc();
      cyc();
      rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         chk("t6_no_write_after_rst", 32'(bus.rf_we_o), 32'd0);
         cyc();
      end
      chk("exp_queue_drained", 32'(exp_q.size()), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
